// File: rtl/pe_pkg.sv
// Shared constants for the MAC PE tile: default datapath widths and sequencer state codes.
// Constants only; no timing or handshake of its own.
package pe_pkg;

  localparam int DEF_WIDTH_A   = 16;
  localparam int DEF_WIDTH_B   = 16;
  localparam int DEF_WIDTH_ACC = 40;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_LEN_W     = 8;
  localparam int DEF_TIMEOUT   = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/mac_addr_gen.sv
// Operand RAM address generator: loads bases on command accept, steps both addresses per issue.
// Addresses are registered (valid the cycle after load/issue); no backpressure, issue is never stalled.
module mac_addr_gen
  import pe_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [LEN_W-1:0]  len,
  input  logic              issue,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              last
);

  logic [LEN_W-1:0] iss_cnt;

  // Address registers wrap naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_addr  <= '0;
      b_addr  <= '0;
      iss_cnt <= '0;
    end else if (load) begin
      a_addr  <= a_base;
      b_addr  <= b_base;
      iss_cnt <= '0;
    end else if (issue) begin
      a_addr  <= a_addr + 1'b1;
      b_addr  <= b_addr + 1'b1;
      iss_cnt <= iss_cnt + 1'b1;
    end
  end

  assign last = issue && (iss_cnt == len - 1'b1);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for one MAC PE: clear, stream len operand pairs, wait for returns, present result.
// Latency 1 + len + PE latency + 1 from accept; one command at a time, result held until res_ready.
module mac_seq_ctrl
  import pe_pkg::*;
#(
  parameter int WIDTH_A   = DEF_WIDTH_A,
  parameter int WIDTH_B   = DEF_WIDTH_B,
  parameter int WIDTH_ACC = DEF_WIDTH_ACC,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic [ADDR_W-1:0]    cmd_a_base,
  input  logic [ADDR_W-1:0]    cmd_b_base,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    a_addr,
  output logic [ADDR_W-1:0]    b_addr,
  input  logic [WIDTH_A-1:0]   a_rdata,
  input  logic [WIDTH_B-1:0]   b_rdata,
  output logic                 pe_en,
  output logic                 pe_clr,
  output logic                 pe_valid_in,
  output logic [WIDTH_A-1:0]   pe_a,
  output logic [WIDTH_B-1:0]   pe_b,
  input  logic                 pe_valid_out,
  input  logic [WIDTH_ACC-1:0] pe_acc,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH_ACC-1:0] res_data,
  output logic                 res_err,
  output logic                 busy
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]       state;
  logic [2:0]       nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] ret_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic             accept;
  logic             last;
  logic             drain_ok;
  logic             tmo_hit;

  assign accept   = (state == ST_IDLE) && cmd_valid;
  assign drain_ok = (state == ST_DRAIN) && (ret_cnt == len_q);
  // A completed drain wins over a timeout landing on the same cycle.
  assign tmo_hit  = (state == ST_DRAIN) && !drain_ok && (tmo_cnt == TW'(TIMEOUT - 1));

  mac_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .a_base (cmd_a_base),
    .b_base (cmd_b_base),
    .len    (len_q),
    .issue  (state == ST_ISSUE),
    .a_addr (a_addr),
    .b_addr (b_addr),
    .last   (last)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (cmd_valid) nxt = (cmd_len == '0) ? ST_DONE : ST_CLEAR;
      ST_CLEAR: nxt = ST_ISSUE;
      ST_ISSUE: if (last) nxt = ST_DRAIN;
      ST_DRAIN: if (drain_ok || tmo_hit) nxt = ST_DONE;
      ST_DONE:  if (res_ready) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      ret_cnt     <= '0;
      tmo_cnt     <= '0;
      pe_valid_in <= 1'b0;
      res_data    <= '0;
      res_err     <= 1'b0;
    end else begin
      state       <= nxt;
      pe_valid_in <= (state == ST_ISSUE);
      tmo_cnt     <= (state == ST_DRAIN) ? tmo_cnt + 1'b1 : '0;
      if (accept) begin
        len_q    <= cmd_len;
        ret_cnt  <= '0;
        res_data <= '0;
        res_err  <= 1'b0;
      end else if (((state == ST_ISSUE) || (state == ST_DRAIN)) && pe_valid_out) begin
        ret_cnt <= ret_cnt + 1'b1;
      end
      if (drain_ok || tmo_hit) begin
        res_data <= pe_acc;
        res_err  <= tmo_hit;
      end
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign rd_en     = (state == ST_ISSUE);
  assign pe_en     = (state != ST_IDLE) && (state != ST_DONE);
  assign pe_clr    = (state == ST_CLEAR);
  assign res_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign pe_a      = a_rdata;
  assign pe_b      = b_rdata;

endmodule
